wptr_full: RTL

WPTR_FULL -- requirements
Module: wptr_full

---
 rtl/wptr_full.sv | 97 +++++++++
 1 files changed

// File: rtl/wptr_full.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wptr_full: write-side pointer, Gray export and full flag of an async FIFO |
// | Optional almost_full output: define WPTR_ALMOST_FULL_EN.   Rev 1.0        |
// +--------------------------------------------------------------------------+
module wptr_full #(
  parameter  int DEPTH    = 16,
  parameter  int AF_LEVEL = DEPTH - 2,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic              wr_clk,
  input  logic              wr_rst,
  input  logic              wr_en,
  input  logic [ADDR_W:0]   rd_gray_ptr,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W:0]   wr_gray_ptr,
  output logic              full,
`ifdef WPTR_ALMOST_FULL_EN
  output logic              almost_full,
`endif
  output logic [ADDR_W:0]   wr_count
);

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || AF_LEVEL > DEPTH) begin : g_bad_params
    $error("wptr_full: DEPTH must be a power of 2 >= 4 and AF_LEVEL <= DEPTH");
  end

  function automatic logic [ADDR_W:0] gray2bin(input logic [ADDR_W:0] g);
    logic [ADDR_W:0] b;
    b[ADDR_W] = g[ADDR_W];
    for (int i = ADDR_W - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [ADDR_W:0] r_rq1;
  logic [ADDR_W:0] r_rq2;
  logic [ADDR_W:0] r_wbin;
  logic [ADDR_W:0] r_wgray;
  logic            r_full;

  logic            w_accept;
  logic [ADDR_W:0] w_wbin_next;
  logic [ADDR_W:0] w_wgray_next;
  logic [ADDR_W:0] w_rbin;
  logic            w_full_next;

  assign w_accept     = wr_en & ~r_full;
  assign w_wbin_next  = r_wbin + {{ADDR_W{1'b0}}, w_accept};
  assign w_wgray_next = w_wbin_next ^ (w_wbin_next >> 1);
  assign w_rbin       = gray2bin(r_rq2);
  // Full when the next write pointer has lapped the read pointer exactly once.
  assign w_full_next  = (w_wgray_next == {~r_rq2[ADDR_W:ADDR_W-1], r_rq2[ADDR_W-2:0]});

  always_ff @(posedge wr_clk or negedge wr_rst) begin
    if (!wr_rst) begin
      r_rq1   <= '0;
      r_rq2   <= '0;
      r_wbin  <= '0;
      r_wgray <= '0;
      r_full  <= 1'b0;
    end else begin
      r_rq1   <= rd_gray_ptr;
      r_rq2   <= r_rq1;
      r_wbin  <= w_wbin_next;
      r_wgray <= w_wgray_next;
      r_full  <= w_full_next;
    end
  end

`ifdef WPTR_ALMOST_FULL_EN
  localparam logic [ADDR_W:0] C_AF_LEVEL = AF_LEVEL[ADDR_W:0];

  logic            r_afull;
  logic [ADDR_W:0] w_occ_next;

  assign w_occ_next = w_wbin_next - w_rbin;

  always_ff @(posedge wr_clk or negedge wr_rst) begin
    if (!wr_rst) begin
      r_afull <= 1'b0;
    end else begin
      r_afull <= (w_occ_next >= C_AF_LEVEL);
    end
  end

  assign almost_full = r_afull;
`endif

  assign wr_ptr      = r_wbin[ADDR_W-1:0];
  assign wr_gray_ptr = r_wgray;
  assign full        = r_full;
  assign wr_count    = r_wbin - w_rbin;

endmodule
`default_nettype wire
